// File: rtl/axil_ic_pkg.sv
// Shared definitions for the AXI-Lite interconnect arbiters: FSM state
// encoding, default sizing, and the round-robin pick function.
package axil_ic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_MASTERS  = 4;
    localparam int DEF_QUANTUM_TIME = 16;
    localparam int MAX_MASTERS      = 16;

    // Round-robin pick: the request vector (n bits used) is laid out twice
    // back to back, every position at or below 'last' is masked off, and
    // the lowest remaining set bit wins. Folding the winner back modulo n
    // gives the first requester strictly after 'last', wrapping around.
    // Returns 0 when nothing is requested; callers only use the result
    // when at least one request bit is set.
    function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req,
                                   input int last,
                                   input int n);
        logic [2*MAX_MASTERS-1:0] dbl;
        int  pick;
        bit  found;
        dbl   = '0;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < 2*MAX_MASTERS; i++) begin
            if (i < n) begin
                dbl[i] = req[i];
            end else if (i < 2*n) begin
                dbl[i] = req[i-n];
            end
        end
        for (int i = 0; i < 2*MAX_MASTERS; i++) begin
            if (!found && (i > last) && dbl[i]) begin
                found = 1'b1;
                pick  = (i >= n) ? (i - n) : i;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/DLock_timer.sv
// Deadlock / quantum timer: counts consecutive cycles with start_i high and
// emits a one-cycle tick after QUANTUM_TIME of them, then starts over.
// A low start_i discards any partial count.
module DLock_timer
    import axil_ic_pkg::*;
#(
    parameter int QUANTUM_TIME = DEF_QUANTUM_TIME
) (
    input  logic clk_i,
    input  logic start_i,
    input  logic resetn_i,
    output logic tick_timer
);

    localparam int CNT_W = $clog2(QUANTUM_TIME);

    logic [CNT_W-1:0] count_reg;

    // Count contended cycles; tick is registered so it lands QUANTUM_TIME
    // cycles after the first high start_i.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            count_reg  <= '0;
            tick_timer <= 1'b0;
        end else begin
            tick_timer <= 1'b0;
            if (!start_i) begin
                count_reg <= '0;
            end else if (count_reg == CNT_W'(QUANTUM_TIME - 1)) begin
                count_reg  <= '0;
                tick_timer <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axil_quantum_arbiter.sv
// Round-robin arbiter for the shared AXI-Lite slave port with a per-owner
// time quantum: a contended owner is preempted when the timer ticks.
module axil_quantum_arbiter
    import axil_ic_pkg::*;
#(
    parameter  int NUM_MASTERS  = DEF_NUM_MASTERS,
    parameter  int QUANTUM_TIME = DEF_QUANTUM_TIME,
    localparam int IDX_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   done_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   grant_valid_o,
    output logic                   preempt_o
);

    arb_state_e             state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic                   valid_reg, valid_next;
    logic                   preempt_reg, preempt_next;

    logic [MAX_MASTERS-1:0] req_ext;
    logic [IDX_W-1:0]       pick_idx;
    logic                   release_now;
    logic                   timer_start;
    logic                   tick;

    // Count only while someone other than the owner is waiting.
    assign timer_start = (state_reg == BUSY) && (|(req_i & ~grant_reg));

    DLock_timer #(
        .QUANTUM_TIME(QUANTUM_TIME)
    ) u_timer (
        .clk_i      (clk_i),
        .start_i    (timer_start),
        .resetn_i   (resetn_i),
        .tick_timer (tick)
    );

    // Widen the request vector to the pick function's fixed width.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_MASTERS-1:0] = req_i;
    end

    assign pick_idx    = IDX_W'(rr_pick(req_ext, int'(last_reg), NUM_MASTERS));
    assign release_now = done_i || !req_i[idx_reg];

    // State, owner and output registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            last_reg    <= IDX_W'(NUM_MASTERS - 1);
            grant_reg   <= '0;
            valid_reg   <= 1'b0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            grant_reg   <= grant_next;
            valid_reg   <= valid_next;
            preempt_reg <= preempt_next;
        end
    end

    // Next-state logic: grant from IDLE, drop to IDLE on release or quantum
    // expiry. Release takes priority over a coincident tick. last_reg is
    // only updated on a new grant, so after a preemption the next scan
    // starts just past the preempted owner.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        grant_next   = grant_reg;
        valid_next   = valid_reg;
        preempt_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_i) begin
                    state_next           = BUSY;
                    idx_next             = pick_idx;
                    last_next            = pick_idx;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    valid_next           = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_next = IDLE;
                    grant_next = '0;
                    valid_next = 1'b0;
                end else if (tick) begin
                    state_next   = IDLE;
                    grant_next   = '0;
                    valid_next   = 1'b0;
                    preempt_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign grant_o       = grant_reg;
    assign grant_idx_o   = idx_reg;
    assign grant_valid_o = valid_reg;
    assign preempt_o     = preempt_reg;

endmodule

// File: tb/tb_axil_quantum_arbiter.sv
// Directed bench for axil_quantum_arbiter with 4 masters and a quantum of 4.
module tb_axil_quantum_arbiter;

    localparam int NM = 4;
    localparam int QT = 4;

    logic          clk;
    logic          resetn;
    logic [NM-1:0] req;
    logic          done;
    logic [NM-1:0] grant;
    logic [1:0]    grant_idx;
    logic          grant_valid;
    logic          preempt;

    int total = 0;
    int bad   = 0;

    axil_quantum_arbiter #(
        .NUM_MASTERS  (NM),
        .QUANTUM_TIME (QT)
    ) dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .req_i         (req),
        .done_i        (done),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .preempt_o     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full registered output set in one go.
    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic v, input logic p);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        if (v) chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".preempt"}, 32'(preempt), 32'(p));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        resetn = 1'b0;
        req    = '0;
        done   = 1'b0;

        // Reset state
        step();
        step();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset.idx0", 32'(grant_idx), 32'd0);
        resetn = 1'b1;

        // 1: first grant goes to master 0, then master 2 after a dead cycle
        req = 4'b0101;
        step();
        chk_all("t1.first", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_all("t1.dead", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk_all("t1.second", 4'b0100, 2'd2, 1'b1, 1'b0);
        req  = 4'b0000;
        step();
        chk_all("t1.drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2: fairness with all masters requesting
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            chk_all($sformatf("t2.grant%0d", i), 4'(1 << seq[i]), 2'(seq[i]), 1'b1, 1'b0);
            done = 1'b1;
            step();
            done = 1'b0;
            chk_all($sformatf("t2.dead%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
            step();
        end
        chk_all("t2.next", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_all("t2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 3: master 1 owns, master 3 arrives -> preempted after the quantum
        req = 4'b0010;
        step();
        chk_all("t3.own", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1010;          // contention starts in cycle k
        step();                 // k+1
        chk_all("t3.k1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();                 // k+2
        step();                 // k+3
        step();                 // k+4: tick cycle, grant still held
        chk_all("t3.k4", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();                 // k+5
        chk_all("t3.k5", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();                 // k+6
        chk_all("t3.k6", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_all("t3.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 4: cancelled quantum, then full quantum after re-raise
        req = 4'b0001;
        step();
        chk_all("t4.own", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0101;
        step();
        step();
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all($sformatf("t4.hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0101;          // re-raised in cycle r
        step();
        step();
        step();
        step();                 // r+4
        chk_all("t4.r4", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();                 // r+5
        chk_all("t4.r5", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();                 // r+6
        chk_all("t4.r6", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_all("t4.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 5: done coincides with the tick -> plain release
        req = 4'b0010;
        step();
        chk_all("t5.own", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0011;          // cycle k
        step();
        step();
        step();
        step();                 // k+4: tick cycle
        done = 1'b1;
        step();                 // k+5
        done = 1'b0;
        chk_all("t5.k5", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();                 // k+6
        chk_all("t5.k6", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk_all("t5.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 6: asynchronous reset while master 2 owns
        req = 4'b0100;
        step();
        chk_all("t6.own", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("t6.idx0", 32'(grant_idx), 32'd0);
        step();
        req    = 4'b0110;
        step();
        chk_all("t6.held", 4'b0000, 2'd0, 1'b0, 1'b0);
        resetn = 1'b1;
        step();
        chk_all("t6.after", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
